// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: FSM encoding,
// control-bundle bit layout and per-boundary data-bundle widths.
package pipe_pkg;

    // Stage occupancy states
    localparam logic [1:0] ST_EMPTY = 2'b00;  // nothing held
    localparam logic [1:0] ST_FULL  = 2'b01;  // main entry live
    localparam logic [1:0] ST_SKID  = 2'b10;  // main and skid entries live

    // Control bundle layout, MSB first
    localparam int CTRL_W       = 12;
    localparam int CTRL_REGWRT  = 11;
    localparam int CTRL_MEMTOREG = 10;
    localparam int CTRL_PCTOREG = 9;
    localparam int CTRL_BRANCHN = 8;
    localparam int CTRL_BRANCHZ = 7;
    localparam int CTRL_JUMP    = 6;
    localparam int CTRL_JUMPMEM = 5;
    localparam int CTRL_MEMREAD = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_IMME    = 2;
    localparam int CTRL_ALUOP   = 0;  // ALUop occupies [CTRL_ALUOP+1:CTRL_ALUOP]

    // Data bundle widths at each pipeline boundary
    localparam int DATA_W_IFID  = 64;   // PC, instruction
    localparam int DATA_W_IDEX  = 128;  // Xrs, Xrt, imm, PC
    localparam int DATA_W_EXMEM = 128;  // Xrt, Y, PC_Y, PC
    localparam int DATA_W_MEMWB = 96;   // mem data, Y, PC_Y

    // Readable view of the control bundle
    typedef struct packed {
        logic       regwrt;
        logic       memtoreg;
        logic       pctoreg;
        logic       branchn;
        logic       branchz;
        logic       jump;
        logic       jumpmem;
        logic       memread;
        logic       memwrite;
        logic       imme;
        logic [1:0] aluop;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One ctrl/data/rd holding register. Clear only zeroes the control bits
// (so a killed entry can never write anything); data and rd keep their
// old values since they are meaningless while the entry is invalid.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 128,
    parameter int RD_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [RD_W-1:0]   d_rd,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [RD_W-1:0]   q_rd
);

    // Falling-edge register: clear beats load
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ctrl <= '0;
            q_data <= '0;
            q_rd   <= '0;
        end else if (clear) begin
            q_ctrl <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
            q_rd   <= d_rd;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, a 2-entry skid
// buffer, flush-to-bubble and a saturating stall counter.
//
// Handshake: a transfer happens on a falling edge where valid and ready
// are both high. in_ready depends only on registered state, so there is
// no combinational path from out_ready back to in_ready. Data accepted on
// one falling edge is visible at the outputs after that same edge, never
// combinationally bypassed.
module pipe_stage_reg #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = 128,
    parameter int RD_W   = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipe_pkg::*;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              accept;
    logic              drain;
    logic              main_load;
    logic              main_from_skid;
    logic              skid_load;

    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [RD_W-1:0]   main_d_rd;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [RD_W-1:0]   skid_rd;

    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // A bubble must never present live control bits downstream
    assign out_ctrl = out_valid ? main_ctrl : '0;

    // Next-state and entry load decisions; flush overrides everything
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (drain && accept) begin
                        main_load = 1'b1;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = ST_FULL;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Main entry refills from the skid entry when one is waiting
    always_comb begin
        main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
        main_d_data = main_from_skid ? skid_data : in_data;
        main_d_rd   = main_from_skid ? skid_rd   : in_rd;
    end

    // Occupancy state register
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Stall counter: held-output edges, saturating, not counted on flush
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .clear  (flush),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .d_rd   (main_d_rd),
        .q_ctrl (main_ctrl),
        .q_data (out_data),
        .q_rd   (out_rd)
    );

    pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .clear  (flush),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .d_rd   (in_rd),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data),
        .q_rd   (skid_rd)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. The reference model is a FIFO of accepted
// instructions with capacity two plus a saturating stall count.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 12;
    localparam int DATA_W = 128;
    localparam int RD_W   = 6;
    localparam int CNT_W  = 4;
    localparam int W      = CTRL_W + DATA_W + RD_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks;
    int n_fails;
    logic [W-1:0] exp_q[$];
    int model_cnt;

    pipe_stage_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .stall_cnt (stall_cnt)
    );

    // Clock: active edge is the falling edge at 10, 20, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied just after the rising edge
    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic [RD_W-1:0] r, input logic ordy, input logic fl);
        @(posedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        in_rd     = r;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, '0, '0, ordy, 1'b0);
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Asynchronous reset pulse between edges; checked before any edge occurs
    task automatic pulse_reset();
        @(posedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_ctrl",  W'(out_ctrl),  W'(0));
        check("rst_in_ready",  W'(in_ready),  W'(1'b1));
        check("rst_stall_cnt", W'(stall_cnt), W'(0));
        exp_q.delete();
        model_cnt = 0;
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard: runs between the rising edge (inputs settled)
    // and the next falling edge; compares outputs and advances the model.
    always @(posedge clk) begin
        #3;
        if (rst_n) begin
            check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
            check("in_ready",  W'(in_ready),  W'(exp_q.size() < 2));
            check("stall_cnt", W'(stall_cnt), W'(model_cnt));
            if (!out_valid) check("bubble_ctrl", W'(out_ctrl), W'(0));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_out: rd %0d with nothing expected at %0t", out_rd, $time);
                    end else begin
                        check("out_item", {out_ctrl, out_data, out_rd}, exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data, in_rd});
                if (out_valid && !out_ready && model_cnt < CNT_MAX) model_cnt++;
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        model_cnt = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        in_rd     = '0;
        out_ready = 1'b0;
        #8;
        check("init_out_valid", W'(out_valid), W'(1'b0));
        check("init_out_ctrl",  W'(out_ctrl),  W'(0));
        check("init_out_data",  W'(out_data),  W'(0));
        check("init_out_rd",    W'(out_rd),    W'(0));
        check("init_in_ready",  W'(in_ready),  W'(1'b1));
        check("init_stall_cnt", W'(stall_cnt), W'(0));
        #4 rst_n = 1'b1;

        // Backpressure: A, B held, two more held edges, then release
        drive(1'b1, 12'h801, rand_data(), 6'd10, 1'b0, 1'b0);
        drive(1'b1, 12'h008, rand_data(), 6'd11, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        @(posedge clk); #2;
        check("bp_in_ready", W'(in_ready), W'(1'b0));
        check("bp_stall3",   W'(stall_cnt), W'(3));
        out_ready = 1'b1;
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Streaming rd 1..8 back-to-back with downstream always ready
        for (int i = 1; i <= 8; i++)
            drive(1'b1, 12'($urandom), rand_data(), 6'(i), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset while both entries are held
        drive(1'b1, 12'hFFF, rand_data(), 6'd20, 1'b0, 1'b0);
        drive(1'b1, 12'hFFF, rand_data(), 6'd21, 1'b0, 1'b0);
        pulse_reset();
        idle(1'b1);

        // Flush in SKID with a simultaneous offer of rd=9
        drive(1'b1, 12'hA5A, rand_data(), 6'd30, 1'b0, 1'b0);
        drive(1'b1, 12'h5A5, rand_data(), 6'd31, 1'b0, 1'b0);
        drive(1'b1, 12'hFFF, rand_data(), 6'd9, 1'b1, 1'b1);
        idle(1'b1);
        @(posedge clk); #2;
        check("flush_out_valid", W'(out_valid), W'(1'b0));
        check("flush_out_ctrl",  W'(out_ctrl),  W'(0));
        check("flush_in_ready",  W'(in_ready),  W'(1'b1));

        // Bubbles with all control bits high on the input
        for (int i = 0; i < 4; i++)
            drive(1'b0, 12'hFFF, rand_data(), 6'd40, 1'b1, 1'b0);

        // Random traffic, occasional flush
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 12'($urandom), rand_data(), 6'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Counter saturation: one entry held for 20 edges
        pulse_reset();
        drive(1'b1, 12'h123, rand_data(), 6'd50, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        @(posedge clk); #2;
        check("sat_stall_cnt", W'(stall_cnt), W'(CNT_MAX));
        idle(1'b0);
        @(posedge clk); #2;
        check("sat_hold", W'(stall_cnt), W'(CNT_MAX));
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        @(posedge clk); #4;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
